grant_dispatcher: RTL and testbench
===================================

GRANT_DISPATCHER -- requirements
Module: grant_dispatcher

Interface
REQ-001 Parameter: NUM_REQ, 3, number of requesters (one-hot grant width); only 3 is supported.
REQ-002 Parameter: TIMEOUT, 16, max cycles a grant is held without done (used only with GRANT_TIMEOUT_EN).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: idx_valid  input  1  encoded priority index presented.
REQ-006 Port: idx  input  2  encoded winner index from the upstream priority selector (0..2 legal, 3 illegal).
REQ-007 Port: idx_ready  output  1  dispatcher can accept an index this cycle.
REQ-008 Port: done  input  3  per-requester release; bit i releases grant i.
REQ-009 Port: gnt  output  3  one-hot grant; all-zero when no grant.
REQ-010 Port: busy  output  1  high while a grant is held.
REQ-011 Port: err  output  1  one-cycle pulse on illegal index accepted.
REQ-012 Port: timeout  output  1  one-cycle pulse on grant timeout; constant 0 without GRANT_TIMEOUT_EN.

Function
REQ-013 FSM states SHALL be IDLE, GRANT, RELEASE; all outputs registered.
REQ-014 IDLE: idx_ready=1, gnt=000, busy=0.
REQ-015 Handshake: index accepted only in a cycle with idx_valid=1 and idx_ready=1.
REQ-016 Legal index i accepted at edge N -> state GRANT, gnt bit i=1, busy=1 visible after edge N (1-cycle latency).
REQ-017 Illegal index (3) accepted -> err=1 for exactly one cycle, state stays IDLE, gnt stays 000.
REQ-018 GRANT: idx_ready=0; gnt held unchanged; idx/idx_valid ignored.
REQ-019 GRANT: done bit matching the granted index -> RELEASE at next edge, gnt=000, busy=0.
REQ-020 GRANT: done bits of non-granted requesters ignored; multiple done bits including the granted bit count as release.
REQ-021 RELEASE: exactly one cycle, idx_ready=0, gnt=000; then IDLE (minimum 1 idle gap between grants).
REQ-022 Back-to-back: idx_valid held high with new index -> next grant issued no earlier than 3 cycles after the previous acceptance.
REQ-023 done asserted during IDLE or RELEASE SHALL be ignored.

Reset
REQ-024 rst=1 at an edge -> state IDLE, gnt=000, busy=0, err=0, timeout=0, idx_ready=1 from next cycle, hold counter cleared.
REQ-025 rst mid-GRANT SHALL drop gnt immediately at that edge with no err/timeout pulse.
REQ-026 rst dominates idx_valid and done in the same cycle.

Configuration
REQ-027 Macro GRANT_TIMEOUT_EN defined: hold counter (width clog2(TIMEOUT+1)) counts cycles in GRANT from 1; on reaching TIMEOUT without matching done -> timeout=1 one cycle, state RELEASE, gnt=000.
REQ-028 Matching done in the same cycle the counter reaches TIMEOUT SHALL count as normal release; no timeout pulse.
REQ-029 Macro undefined: no counter; grant held indefinitely until done; timeout tied 0.

Structure
REQ-030 Package grant_pkg SHALL hold NUM_REQ, index width, and the FSM state encoding (IDLE=0, GRANT=1, RELEASE=2).
REQ-031 One sub-module idx_decoder SHALL map 2-bit idx to 3-bit one-hot plus an illegal flag (combinational).

Verification
REQ-032 Reset: rst=1 two cycles -> gnt=000, busy=0, idx_ready=1, err=0, timeout=0.
REQ-033 idx=2 valid one cycle, done=100 three cycles later -> gnt=100 from next edge, 000 after done, idx_ready=1 one cycle after RELEASE.
REQ-034 idx=3 valid -> err=1 exactly one cycle, gnt=000, state IDLE.
REQ-035 idx=0 granted, done=010 then done=001 -> gnt=001 held through done=010, released on done=001.
REQ-036 GRANT_TIMEOUT_EN, TIMEOUT=16, idx=1, no done -> timeout=1 exactly 16 cycles after grant, gnt=000; without macro gnt=010 held 100 cycles.
REQ-037 idx=0 granted, rst=1 after 3 cycles -> gnt=000 next edge, no err/timeout pulse.

Source files
------------

// File: rtl/grant_pkg.sv
// Shared constants and FSM encoding for the grant dispatcher.
// Consumed by grant_dispatcher and idx_decoder.
package grant_pkg;

    localparam int NUM_REQ = 3;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/grant_dispatcher_idx_decoder.sv
// Encoded priority index to one-hot grant vector.
// Index 3 has no requester and is flagged as illegal.
module idx_decoder
    import grant_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot,
    output logic               illegal
);

    always_comb begin
        onehot  = '0;
        illegal = 1'b0;
        unique case (idx)
            2'd0:    onehot  = 3'b001;
            2'd1:    onehot  = 3'b010;
            2'd2:    onehot  = 3'b100;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/grant_dispatcher.sv
// Single-grant dispatcher: IDLE -> GRANT -> RELEASE, all outputs registered.
// Optional hold-time watchdog enabled by defining GRANT_TIMEOUT_EN.
module grant_dispatcher
    import grant_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               idx_valid,
    input  logic [IDX_W-1:0]   idx,
    output logic               idx_ready,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] gnt,
    output logic               busy,
    output logic               err,
    output logic               timeout
);

    state_t state_q, state_d;

    logic [NUM_REQ-1:0] dec_onehot;
    logic               dec_illegal;
    logic               accept;
    logic               release_hit;
    logic               to_hit;

    logic [NUM_REQ-1:0] gnt_d;
    logic               busy_d;
    logic               err_d;
    logic               timeout_d;
    logic               idx_ready_d;

    idx_decoder u_dec (
        .idx     (idx),
        .onehot  (dec_onehot),
        .illegal (dec_illegal)
    );

    assign accept      = idx_valid & idx_ready;
    assign release_hit = |(done & gnt);

`ifdef GRANT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    assign to_hit = (state_q == GRANT) && (cnt_q == CNT_W'(TIMEOUT));

    // First GRANT cycle reads 1, so the limit lands TIMEOUT cycles after grant
    always_ff @(posedge clk) begin
        if (rst || state_d != GRANT) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= CNT_W'(1);
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
`else
    logic unused_timeout_cfg;

    assign to_hit             = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            timeout   <= 1'b0;
            idx_ready <= 1'b1;
        end else begin
            state_q   <= state_d;
            gnt       <= gnt_d;
            busy      <= busy_d;
            err       <= err_d;
            timeout   <= timeout_d;
            idx_ready <= idx_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && !dec_illegal) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (release_hit || to_hit) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Release wins over timeout when both land in the same cycle
    always_comb begin
        gnt_d       = '0;
        if (state_d == GRANT) begin
            gnt_d = (state_q == IDLE) ? dec_onehot : gnt;
        end
        busy_d      = (state_d == GRANT);
        idx_ready_d = (state_d == IDLE);
        err_d       = (state_q == IDLE) && accept && dec_illegal;
        timeout_d   = to_hit && !release_hit;
    end

endmodule

// File: tb/tb_grant_dispatcher.sv
// Directed-vector bench for grant_dispatcher.
// Covers both builds of GRANT_TIMEOUT_EN.
module tb_grant_dispatcher;

    logic       clk = 1'b0;
    logic       rst;
    logic       idx_valid;
    logic [1:0] idx;
    logic       idx_ready;
    logic [2:0] done;
    logic [2:0] gnt;
    logic       busy;
    logic       err;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    grant_dispatcher #(
        .NUM_REQ (3),
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .idx_valid (idx_valid),
        .idx       (idx),
        .idx_ready (idx_ready),
        .done      (done),
        .gnt       (gnt),
        .busy      (busy),
        .err       (err),
        .timeout   (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [2:0] g,
                             input logic b, input logic r);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".ready"}, 32'(idx_ready), 32'(r));
    endtask

    initial begin
        rst       = 1'b1;
        idx_valid = 1'b0;
        idx       = 2'd0;
        done      = 3'b000;

        tick();
        tick();
        rst = 1'b0;
        chk_state("reset", 3'b000, 1'b0, 1'b1);
        chk("reset.err", 32'(err), 32'd0);
        chk("reset.timeout", 32'(timeout), 32'd0);

        // idx=2, done=100 three cycles after acceptance
        idx_valid = 1'b1;
        idx       = 2'd2;
        tick();
        idx_valid = 1'b0;
        chk_state("g2.acc", 3'b100, 1'b1, 1'b0);
        tick();
        chk_state("g2.hold1", 3'b100, 1'b1, 1'b0);
        tick();
        chk_state("g2.hold2", 3'b100, 1'b1, 1'b0);
        done = 3'b100;
        tick();
        done = 3'b000;
        chk_state("g2.rel", 3'b000, 1'b0, 1'b0);
        tick();
        chk_state("g2.idle", 3'b000, 1'b0, 1'b1);

        // done in IDLE has no effect
        done = 3'b111;
        tick();
        done = 3'b000;
        chk_state("idle.done", 3'b000, 1'b0, 1'b1);

        // illegal index
        idx_valid = 1'b1;
        idx       = 2'd3;
        tick();
        idx_valid = 1'b0;
        chk("ill.err", 32'(err), 32'd1);
        chk_state("ill", 3'b000, 1'b0, 1'b1);
        tick();
        chk("ill.err_off", 32'(err), 32'd0);

        // non-granted done ignored
        idx_valid = 1'b1;
        idx       = 2'd0;
        tick();
        idx_valid = 1'b0;
        chk_state("g0.acc", 3'b001, 1'b1, 1'b0);
        done = 3'b010;
        tick();
        chk_state("g0.other", 3'b001, 1'b1, 1'b0);
        done = 3'b001;
        tick();
        done = 3'b000;
        chk_state("g0.rel", 3'b000, 1'b0, 1'b0);
        tick();
        chk_state("g0.idle", 3'b000, 1'b0, 1'b1);

        // back-to-back with idx_valid held high
        idx_valid = 1'b1;
        idx       = 2'd1;
        tick();
        chk_state("b2b.g1", 3'b010, 1'b1, 1'b0);
        idx = 2'd0;
        tick();
        chk_state("b2b.ign", 3'b010, 1'b1, 1'b0);
        done = 3'b011;
        tick();
        done = 3'b000;
        chk_state("b2b.rel", 3'b000, 1'b0, 1'b0);
        tick();
        chk_state("b2b.gap", 3'b000, 1'b0, 1'b1);
        tick();
        chk_state("b2b.g0", 3'b001, 1'b1, 1'b0);
        idx_valid = 1'b0;
        done      = 3'b001;
        tick();
        done = 3'b000;
        chk_state("b2b.rel2", 3'b000, 1'b0, 1'b0);
        tick();
        chk_state("b2b.idle", 3'b000, 1'b0, 1'b1);

        // reset in the middle of a grant
        idx_valid = 1'b1;
        idx       = 2'd0;
        tick();
        idx_valid = 1'b0;
        chk_state("rg.acc", 3'b001, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        rst       = 1'b1;
        idx_valid = 1'b1;
        idx       = 2'd2;
        done      = 3'b001;
        tick();
        chk_state("rg.rst", 3'b000, 1'b0, 1'b1);
        chk("rg.err", 32'(err), 32'd0);
        chk("rg.timeout", 32'(timeout), 32'd0);
        tick();
        chk_state("rg.dom", 3'b000, 1'b0, 1'b1);
        rst       = 1'b0;
        idx_valid = 1'b0;
        done      = 3'b000;

        // hold without done
        idx_valid = 1'b1;
        idx       = 2'd1;
        tick();
        idx_valid = 1'b0;
        chk_state("to.acc", 3'b010, 1'b1, 1'b0);
`ifdef GRANT_TIMEOUT_EN
        for (int k = 1; k < 16; k++) begin
            tick();
            chk("to.wait.timeout", 32'(timeout), 32'd0);
            chk("to.wait.gnt", 32'(gnt), 32'b010);
        end
        tick();
        chk("to.pulse", 32'(timeout), 32'd1);
        chk_state("to.rel", 3'b000, 1'b0, 1'b0);
        tick();
        chk("to.pulse_off", 32'(timeout), 32'd0);
        chk_state("to.idle", 3'b000, 1'b0, 1'b1);

        // matching done on the limit cycle is a normal release
        idx_valid = 1'b1;
        idx       = 2'd2;
        tick();
        idx_valid = 1'b0;
        for (int k = 1; k < 16; k++) begin
            tick();
        end
        chk("tr.pre", 32'(gnt), 32'b100);
        done = 3'b100;
        tick();
        done = 3'b000;
        chk("tr.timeout", 32'(timeout), 32'd0);
        chk_state("tr.rel", 3'b000, 1'b0, 1'b0);
        tick();
`else
        for (int k = 0; k < 100; k++) begin
            tick();
            chk("hold.gnt", 32'(gnt), 32'b010);
            chk("hold.timeout", 32'(timeout), 32'd0);
        end
        done = 3'b010;
        tick();
        done = 3'b000;
        chk_state("hold.rel", 3'b000, 1'b0, 1'b0);
        tick();
`endif
        chk_state("end.idle", 3'b000, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
